// File: rtl/led_button_ctrl.sv
// ---------------------------------------------------------------------------
// led_button_ctrl
//
// Button-to-LED controller for board bring-up designs. Raw active-low
// buttons are synchronised and debounced, and each debounced press produces
// a one-cycle pulse. Button 0 increments and button 1 decrements an N_LED-bit
// counter. Button 2 steps the display mode (binary, one-hot, blink).
// Buttons 3 and above only report their level and press pulse.
//
// Optional feature macro: LONG_PRESS_EN
//   When defined, holding button 0 for LONG_CYCLES cycles clears the counter
//   once per hold. When undefined, no hold logic exists and LONG_CYCLES has
//   no effect on behaviour.
//
// Ports
//   clk          in   1      system clock
//   rst          in   1      asynchronous, active-high reset
//   btn_n        in   N_BTN  raw buttons, active-low, asynchronous to clk
//   btn_level    out  N_BTN  debounced level, 1 = pressed
//   btn_pressed  out  N_BTN  one-cycle pulse on debounced release->press
//   led          out  N_LED  registered LED drive, 1 = lit
//   mode         out  2      current display mode (0 BIN, 1 ONEHOT, 2 BLINK)
// ---------------------------------------------------------------------------
module led_button_ctrl #(
    parameter int N_BTN           = 3,
    parameter int N_LED           = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_CYCLES    = 5000000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pressed,
    output logic [N_LED-1:0] led,
    output logic [1:0]       mode
);

    localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int              BL_W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_BIN    = 2'd0,
        MODE_ONEHOT = 2'd1,
        MODE_BLINK  = 2'd2
    } mode_e;

    // Parameter sanity checks, evaluated at elaboration only.
    if (N_BTN < 3) begin : g_chk_btn
        $error("led_button_ctrl: N_BTN must be at least 3");
    end
    if (N_LED < 1) begin : g_chk_led
        $error("led_button_ctrl: N_LED must be at least 1");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
        $error("led_button_ctrl: DEBOUNCE_CYCLES must be at least 2");
    end
    if (BLINK_CYCLES < 1) begin : g_chk_blink
        $error("led_button_ctrl: BLINK_CYCLES must be at least 1");
    end
    if (LONG_CYCLES < 1) begin : g_chk_long
        $error("led_button_ctrl: LONG_CYCLES must be at least 1");
    end

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] pressed_raw;
    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic [BL_W-1:0]  blink_cnt;
    logic             blink_phase;
    logic [N_LED-1:0] count;
    logic [N_LED-1:0] led_d;
    logic             long_clear;
    mode_e            mode_q;
    mode_e            mode_d;

    // Two-flop synchroniser. Flops reset to 1 so every button starts released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign pressed_raw = ~sync2;

    // Debounce: a new level is accepted only after it has differed from the
    // current level for DEBOUNCE_CYCLES consecutive cycles. The press pulse
    // is registered on the same edge that the level rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
            btn_level   <= '0;
            btn_pressed <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                btn_pressed[i] <= 1'b0;
                if (pressed_raw[i] != btn_level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        btn_level[i]   <= pressed_raw[i];
                        btn_pressed[i] <= pressed_raw[i];
                        db_cnt[i]      <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Blink timebase free-runs in every mode so the phase stays continuous
    // across mode changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BL_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BL_W'(1);
        end
    end

`ifdef LONG_PRESS_EN
    localparam int              LG_W    = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

    logic [LG_W-1:0] hold_cnt;
    logic            hold_done;

    // hold_done makes the clear one-shot; it only rearms once btn0 is released.
    assign long_clear = btn_level[0] && !hold_done && (hold_cnt == LG_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
        end else if (!btn_level[0]) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
        end else if (long_clear) begin
            hold_done <= 1'b1;
        end else if (!hold_done) begin
            hold_cnt <= hold_cnt + LG_W'(1);
        end
    end
`else
    assign long_clear = 1'b0;
`endif

    // Up/down counter, modulo 2^N_LED. Simultaneous inc and dec cancel, and a
    // long-press clear overrides both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (long_clear) begin
            count <= '0;
        end else begin
            case ({btn_pressed[1], btn_pressed[0]})
                2'b01:   count <= count + N_LED'(1);
                2'b10:   count <= count - N_LED'(1);
                default: count <= count;
            endcase
        end
    end

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_BIN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode sequencing. The unused encoding falls back to BIN on the next edge.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_BIN:    if (btn_pressed[2]) mode_d = MODE_ONEHOT;
            MODE_ONEHOT: if (btn_pressed[2]) mode_d = MODE_BLINK;
            MODE_BLINK:  if (btn_pressed[2]) mode_d = MODE_BIN;
            default:     mode_d = MODE_BIN;
        endcase
    end

    // LED pattern for the current mode. ONEHOT folds the counter into the
    // available LED positions with a modulo.
    always_comb begin
        led_d = '0;
        case (mode_q)
            MODE_BIN:    led_d = count;
            MODE_ONEHOT: led_d = N_LED'(1) << (32'(count) % N_LED);
            MODE_BLINK:  led_d = blink_phase ? count : '0;
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= led_d;
        end
    end

    assign mode = mode_q;

endmodule
